prf_wb_arbiter: RTL and testbench

Writeback arbiter between the functional units and the physical register file write ports. Each of `N_REQ` FU completion streams gets a one-entry holding buffer. Every cycle, up to `N_PORTS` buffered results are granted round-robin onto registered write ports that drive the PRF and the CDB tag broadcast. Writes to physical register 0 are absorbed without consuming a port.

---
 rtl/prf_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_prf_wb_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: one holding buffer per FU result stream, round-robin grant of up to
// N_PORTS buffered results onto registered PRF write / CDB ports. Optional WB_ARB_PERF_EN adds a stall counter.
module prf_wb_arbiter #(
  parameter int N_REQ      = 7,
  parameter int N_PORTS    = 3,
  parameter int XLEN       = 32,
  parameter int N_PHYS_REG = 64,
  parameter int IDX_W      = $clog2(N_PHYS_REG)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][IDX_W-1:0]      req_idx,
  input  logic [N_REQ-1:0][XLEN-1:0]       req_value,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_PORTS-1:0]               wr_en,
  output logic [N_PORTS-1:0][IDX_W-1:0]    wr_idx,
  output logic [N_PORTS-1:0][XLEN-1:0]     wr_value
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]                      perf_stall_cnt
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]                 buf_valid;
  logic [N_REQ-1:0][IDX_W-1:0]      buf_idx;
  logic [N_REQ-1:0][XLEN-1:0]       buf_value;
  logic [PTR_W-1:0]                 rr_ptr;

  logic [N_REQ-1:0]                 grant;
  logic [N_REQ-1:0]                 accept;
  logic [N_PORTS-1:0]               port_vld;
  logic [N_PORTS-1:0][PTR_W-1:0]    port_sel;
  logic [PTR_W-1:0]                 last_gnt;
  logic [PTR_W-1:0]                 next_ptr;
  logic [PTR_W-1:0]                 cand;
  logic [PTR_W:0]                   scan_sum;
  int                               n_gnt;

  // Scan from rr_ptr with wraparound; the k-th buffered entry found lands on port k.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    port_sel = '0;
    last_gnt = '0;
    scan_sum = '0;
    cand     = '0;
    n_gnt    = 0;
    for (int j = 0; j < N_REQ; j++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(j);
      if (scan_sum >= (PTR_W+1)'(N_REQ))
        scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
      cand = scan_sum[PTR_W-1:0];
      if (buf_valid[cand] && (n_gnt < N_PORTS)) begin
        grant[cand] = 1'b1;
        for (int p = 0; p < N_PORTS; p++) begin
          if (n_gnt == p) begin
            port_vld[p] = 1'b1;
            port_sel[p] = cand;
          end
        end
        n_gnt    = n_gnt + 1;
        last_gnt = cand;
      end
    end
  end

  assign next_ptr = (last_gnt == PTR_W'(N_REQ-1)) ? '0 : last_gnt + PTR_W'(1);

  // Handshake: a result transfers at an edge where req_valid[i] & req_ready[i] are both high.
  // req_ready is a function of arbiter state, flush and reset only, never of req_valid.
  assign req_ready = !reset ? '0 : (flush ? '1 : (~buf_valid | grant));
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid <= '0;
      buf_idx   <= '0;
      buf_value <= '0;
      rr_ptr    <= '0;
      wr_en     <= '0;
      wr_idx    <= '0;
      wr_value  <= '0;
    end else if (flush) begin
      buf_valid <= '0;
      wr_en     <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        // Results for p0 are absorbed here: accepted but never buffered.
        if (accept[i] && (req_idx[i] != '0)) begin
          buf_valid[i] <= 1'b1;
          buf_idx[i]   <= req_idx[i];
          buf_value[i] <= req_value[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      for (int p = 0; p < N_PORTS; p++) begin
        wr_en[p]    <= port_vld[p];
        wr_idx[p]   <= port_vld[p] ? buf_idx[port_sel[p]]   : '0;
        wr_value[p] <= port_vld[p] ? buf_value[port_sel[p]] : '0;
      end
      if (|grant)
        rr_ptr <= next_ptr;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic stall;
  assign stall = |(buf_valid & ~grant);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      perf_stall_cnt <= '0;
    else if (stall && (perf_stall_cnt != 32'hFFFF_FFFF))
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed bench for prf_wb_arbiter: a table of per-cycle vectors plus hand-written
// sequences for reset, p0 writes, flush and mid-operation reset.
module tb_prf_wb_arbiter;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic [6:0]           req_valid;
  logic [6:0][5:0]      req_idx;
  logic [6:0][31:0]     req_value;
  logic [6:0]           req_ready;
  logic [2:0]           wr_en;
  logic [2:0][5:0]      wr_idx;
  logic [2:0][31:0]     wr_value;
`ifdef WB_ARB_PERF_EN
  logic [31:0]          perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  prf_wb_arbiter #(.N_REQ(7), .N_PORTS(3), .XLEN(32), .N_PHYS_REG(64)) dut (
    .clock     (clk),
    .reset     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_value (req_value),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_value  (wr_value)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]      vld;
    logic [5:0]      seed;
    logic            flsh;
    logic [6:0]      rdy;
    logic [2:0]      en;
    logic [2:0][5:0] idx;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] val_of(input logic [5:0] idx);
    return 32'hCAFE_0000 | {26'd0, idx};
  endfunction

  function automatic logic [2:0][31:0] exp_vals(input logic [2:0] en, input logic [2:0][5:0] idx);
    logic [2:0][31:0] r;
    for (int p = 0; p < 3; p++) r[p] = en[p] ? val_of(idx[p]) : 32'd0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_wr(input string name, input logic [2:0] en,
                          input logic [2:0][5:0] idx, input logic [2:0][31:0] val);
    chk({name, "_en"},    {125'd0, wr_en},  {125'd0, en});
    chk({name, "_idx"},   {110'd0, wr_idx}, {110'd0, idx});
    chk({name, "_value"}, {32'd0, wr_value}, {32'd0, val});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid = '0;
    req_idx   = '0;
    req_value = '0;
    flush     = 1'b0;
  endtask

  task automatic drive_seed(input logic [6:0] vld, input logic [5:0] seed);
    req_valid = vld;
    for (int i = 0; i < 7; i++) begin
      req_idx[i]   = seed + 6'(i);
      req_value[i] = val_of(req_idx[i]);
    end
  endtask

  initial begin
    // Burst from rr_ptr=0 (idx 10..16), then a refill-on-grant burst (idx 20..26, FU0 refilled with 30).
    tbl[0] = '{7'h7F, 6'd10, 1'b0, 7'h7F, 3'b000, {6'd0,  6'd0,  6'd0 }};
    tbl[1] = '{7'h00, 6'd10, 1'b0, 7'h07, 3'b111, {6'd12, 6'd11, 6'd10}};
    tbl[2] = '{7'h00, 6'd10, 1'b0, 7'h3F, 3'b111, {6'd15, 6'd14, 6'd13}};
    tbl[3] = '{7'h00, 6'd10, 1'b0, 7'h7F, 3'b001, {6'd0,  6'd0,  6'd16}};
    tbl[4] = '{7'h00, 6'd10, 1'b0, 7'h7F, 3'b000, {6'd0,  6'd0,  6'd0 }};
    tbl[5] = '{7'h7F, 6'd20, 1'b0, 7'h7F, 3'b000, {6'd0,  6'd0,  6'd0 }};
    tbl[6] = '{7'h01, 6'd30, 1'b0, 7'h07, 3'b111, {6'd22, 6'd21, 6'd20}};
    tbl[7] = '{7'h00, 6'd30, 1'b0, 7'h3E, 3'b111, {6'd25, 6'd24, 6'd23}};
    tbl[8] = '{7'h00, 6'd30, 1'b0, 7'h7F, 3'b011, {6'd0,  6'd30, 6'd26}};
    tbl[9] = '{7'h00, 6'd30, 1'b0, 7'h7F, 3'b000, {6'd0,  6'd0,  6'd0 }};

    // Reset held low: outputs quiet, no readiness.
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_wr_en",    {125'd0, wr_en},    128'd0);
    chk("rst_wr_idx",   {110'd0, wr_idx},   128'd0);
    chk("rst_wr_value", {32'd0, wr_value},  128'd0);
    chk("rst_ready",    {121'd0, req_ready}, 128'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("idle_ready", {121'd0, req_ready}, {121'd0, 7'h7F});
    step();
    chk("idle_wr_en0", {125'd0, wr_en}, 128'd0);
    step();
    chk("idle_wr_en1", {125'd0, wr_en}, 128'd0);

    // Single request: FU2, idx 5, value 0xDEAD.
    req_valid    = 7'b0000100;
    req_idx[2]   = 6'd5;
    req_value[2] = 32'hDEAD;
    #1;
    chk("single_ready", {121'd0, req_ready}, {121'd0, 7'h7F});
    step();
    idle_inputs();
    chk("single_e0_en", {125'd0, wr_en}, 128'd0);
    step();
    check_wr("single_e1", 3'b001, {6'd0, 6'd0, 6'd5}, {32'd0, 32'd0, 32'hDEAD});
    step();
    chk("single_e2_en", {125'd0, wr_en}, 128'd0);

    // Return rr_ptr to 0 before the table.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    for (int r = 0; r < 10; r++) begin
      flush = tbl[r].flsh;
      drive_seed(tbl[r].vld, tbl[r].seed);
      #1;
      chk($sformatf("row%0d_ready", r), {121'd0, req_ready}, {121'd0, tbl[r].rdy});
      step();
      check_wr($sformatf("row%0d", r), tbl[r].en, tbl[r].idx, exp_vals(tbl[r].en, tbl[r].idx));
`ifdef WB_ARB_PERF_EN
      if (r == 4) chk("perf_after_burst", {96'd0, perf_stall_cnt}, 128'd2);
`endif
    end
    idle_inputs();
`ifdef WB_ARB_PERF_EN
    chk("perf_after_table", {96'd0, perf_stall_cnt}, 128'd4);
`endif

    // Zero register: FU1 idx 0 is accepted and vanishes; FU3 idx 9 goes through.
    req_valid    = 7'b0001010;
    req_idx[1]   = 6'd0;
    req_value[1] = 32'h1111;
    req_idx[3]   = 6'd9;
    req_value[3] = val_of(6'd9);
    #1;
    chk("zero_ready", {121'd0, req_ready}, {121'd0, 7'h7F});
    step();
    idle_inputs();
    chk("zero_e0_en", {125'd0, wr_en}, 128'd0);
    chk("zero_e0_ready", {121'd0, req_ready}, {121'd0, 7'h7F});
    step();
    check_wr("zero_e1", 3'b001, {6'd0, 6'd0, 6'd9}, {32'd0, 32'd0, val_of(6'd9)});
    step();
    chk("zero_e2_en", {125'd0, wr_en}, 128'd0);

    // Flush with five buffered entries; requests during the flush cycle are dropped.
    drive_seed(7'h1F, 6'd40);
    step();
    flush = 1'b1;
    drive_seed(7'h7F, 6'd50);
    #1;
    chk("flush_ready", {121'd0, req_ready}, {121'd0, 7'h7F});
    step();
    idle_inputs();
    chk("flush_e1_en", {125'd0, wr_en}, 128'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("flush_after%0d_en", c), {125'd0, wr_en}, 128'd0);
    end
    chk("flush_after_ready", {121'd0, req_ready}, {121'd0, 7'h7F});

    // Reset asserted mid-operation drops everything pending.
    drive_seed(7'h7F, 6'd20);
    step();
    idle_inputs();
    step();
    chk("midrst_pre_en", {125'd0, wr_en}, {125'd0, 3'b111});
    rst_n = 1'b0;
    #1;
    chk("midrst_en",    {125'd0, wr_en},     128'd0);
    chk("midrst_ready", {121'd0, req_ready}, 128'd0);
    #1;
    rst_n = 1'b1;
    step();
    chk("midrst_post0_en", {125'd0, wr_en}, 128'd0);
    step();
    chk("midrst_post1_en", {125'd0, wr_en}, 128'd0);
    chk("midrst_post_ready", {121'd0, req_ready}, {121'd0, 7'h7F});

`ifdef WB_ARB_PERF_EN
    // Saturation: preload near max, then two stall cycles.
    force dut.perf_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.perf_stall_cnt;
    drive_seed(7'h7F, 6'd10);
    step();
    idle_inputs();
    step();
    step();
    step();
    chk("perf_saturate", {96'd0, perf_stall_cnt}, {96'd0, 32'hFFFF_FFFF});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
